hazard_scoreboard: RTL

- Parametrised stall/hazard controller for the 5-stage MIPS pipeline; successor to the fixed E/M stall logic.
- Holds its own scoreboard of in-flight register writers over DEPTH post-D stages, instead of taking per-stage A3/Tnew/RegWrite inputs.
- Owns an internal multiply/divide busy countdown and CP0-write tracking for eret serialisation.
- Drives PC enable, D-register enable and E-bubble insertion; keeps a saturating stall-cycle counter.

---
 rtl/hazard_scoreboard.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Stall/hazard controller for the 5-stage pipeline: tracks in-flight GPR writers,
// the mult/div busy window and pending CP0 writes, and drives the stall controls.
module hazard_scoreboard #(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int TW       = 2,
  parameter int DEPTH    = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      d_valid,
  input  logic [NUM_SRC*REG_AW-1:0] d_src_idx,
  input  logic [NUM_SRC*TW-1:0]     d_src_tuse,
  input  logic                      d_we,
  input  logic [REG_AW-1:0]         d_dst,
  input  logic [TW-1:0]             d_tnew,
  input  logic [1:0]                d_md_op,
  input  logic                      d_cp0_wr,
  input  logic                      d_is_eret,
  input  logic                      flush,
  input  logic                      cnt_clr,
  output logic                      stall,
  output logic                      pc_en,
  output logic                      d_en,
  output logic                      e_bubble,
  output logic [2:0]                stall_cause,
  output logic                      md_busy,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int MDW    = $clog2(MD_MAX + 1);

  logic [DEPTH-1:0]             r_v;
  logic [DEPTH-1:0]             r_cp0;
  logic [DEPTH-1:0][REG_AW-1:0] r_dst;
  logic [DEPTH-1:0][TW-1:0]     r_tnew;
  logic [MDW-1:0]               r_md_cnt;
  logic [CNT_W-1:0]             r_stall_cnt;

  logic              w_data_haz;
  logic              w_md_haz;
  logic              w_cp0_haz;
  logic              w_stall;
  logic              w_issue;
  logic              w_md_busy;
  logic              w_hit;
  logic [TW-1:0]     w_hit_tnew;
  logic [REG_AW-1:0] w_src;
  logic [TW-1:0]     w_tuse;

  // Scan oldest to youngest so the youngest matching writer is the one kept.
  always_comb begin
    w_data_haz = 1'b0;
    w_hit      = 1'b0;
    w_hit_tnew = '0;
    w_src      = '0;
    w_tuse     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_src      = d_src_idx[i*REG_AW +: REG_AW];
      w_tuse     = d_src_tuse[i*TW +: TW];
      w_hit      = 1'b0;
      w_hit_tnew = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (r_v[k] && (r_dst[k] == w_src)) begin
          w_hit      = 1'b1;
          w_hit_tnew = r_tnew[k];
        end
      end
      if ((w_tuse != {TW{1'b1}}) && w_hit && (w_hit_tnew > w_tuse)) begin
        w_data_haz = 1'b1;
      end
    end
  end

  assign w_md_busy = (r_md_cnt != '0);
  assign w_md_haz  = d_valid & (d_md_op != 2'b00) & w_md_busy;
  assign w_cp0_haz = d_valid & d_is_eret & (|r_cp0);
  assign w_stall   = d_valid & (w_data_haz | w_md_haz | w_cp0_haz);
  assign w_issue   = d_valid & ~w_stall;

  assign stall       = w_stall;
  assign pc_en       = ~w_stall;
  assign d_en        = ~w_stall;
  assign e_bubble    = w_stall;
  assign stall_cause = {w_cp0_haz, w_md_haz, d_valid & w_data_haz};
  assign md_busy     = w_md_busy;
  assign stall_cnt   = r_stall_cnt;

  // cp0 bit travels even for non-writing entries so eret sees every mtc0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v    <= '0;
      r_cp0  <= '0;
      r_dst  <= '0;
      r_tnew <= '0;
    end else if (flush) begin
      r_v    <= '0;
      r_cp0  <= '0;
      r_dst  <= '0;
      r_tnew <= '0;
    end else begin
      r_v[0]    <= w_issue & d_we & (d_dst != '0);
      r_cp0[0]  <= w_issue & d_cp0_wr;
      r_dst[0]  <= d_dst;
      r_tnew[0] <= d_tnew;
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k]    <= r_v[k-1];
        r_cp0[k]  <= r_cp0[k-1];
        r_dst[k]  <= r_dst[k-1];
        r_tnew[k] <= (r_tnew[k-1] != '0) ? r_tnew[k-1] - TW'(1) : '0;
      end
    end
  end

  // Countdown keeps running through flushes; only reset cancels it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_cnt <= '0;
    end else if (w_issue && (d_md_op == 2'b01)) begin
      r_md_cnt <= MDW'(MULT_LAT);
    end else if (w_issue && (d_md_op == 2'b10)) begin
      r_md_cnt <= MDW'(DIV_LAT);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - MDW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule
